// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared types and defaults for the sorter result serializer
package sort_pkg;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] elem_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

endpackage

// File: rtl/sort_result_serializer.sv
// rtl/sort_result_serializer.sv - ping-pong buffered serializer of sorted vectors
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int WIDTH = sort_pkg::WIDTH,
    parameter int DEPTH = sort_pkg::DEPTH,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        vec_valid,
    input  logic [DEPTH-1:0][WIDTH-1:0] vec_data,
    output logic                        vec_ready,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [WIDTH-1:0]            m_data,
    output logic [IW-1:0]               m_index,
    output logic                        m_last,
    output logic                        overflow,
    output logic [7:0]                  drop_count,
    input  logic                        ovf_clr
);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    ser_state_e       state;
    logic [WIDTH-1:0] slot [2][DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IW-1:0]    idx;

    logic             hs;
    logic             rel;
    logic             accept;
    logic             drop;
    logic [1:0]       count_nxt;

    // Handshake / release / capture decisions for this cycle
    always_comb begin
        hs        = m_valid && m_ready;
        rel       = hs && (idx == LAST_IDX);
        accept    = vec_valid && ((count != 2'd2) || rel);
        drop      = vec_valid && !accept;
        count_nxt = count + {1'b0, accept} - {1'b0, rel};
    end

    // Slot storage: the sorter result lands in the slot the write pointer names
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[wr_ptr][i] <= vec_data[i];
            end
        end
    end

    // Serializer FSM with slot occupancy and pointer bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
        end else begin
            count <= count_nxt;
            if (accept) begin
                wr_ptr <= ~wr_ptr;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= STREAM;
                        idx   <= '0;
                    end
                end
                STREAM: begin
                    if (rel) begin
                        // Next vector follows without a bubble if one is held or arriving now
                        idx    <= '0;
                        rd_ptr <= ~rd_ptr;
                        state  <= (count_nxt != 2'd0) ? STREAM : IDLE;
                    end else if (hs) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop accounting; a clear wins over a drop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (ovf_clr) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Outputs come straight from registers; data reads as zero when no beat is offered
    assign m_valid   = (state == STREAM);
    assign m_index   = idx;
    assign m_last    = m_valid && (idx == LAST_IDX);
    assign m_data    = m_valid ? slot[rd_ptr][idx] : '0;
    assign vec_ready = (count != 2'd2);

endmodule

// File: tb/tb_sort_result_serializer.sv
// tb/tb_sort_result_serializer.sv - self-checking bench for sort_result_serializer
module tb_sort_result_serializer;

    localparam int W = 32;
    localparam int D = 8;

    typedef logic [D-1:0][W-1:0] vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic [2:0]   index;
        logic         last;
    } beat_t;

    typedef struct {
        vec_t vec;
        bit   bp;
    } rec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           vec_valid;
    vec_t           vec_data;
    logic           vec_ready;
    logic           m_valid;
    logic           m_ready;
    logic [W-1:0]   m_data;
    logic [2:0]     m_index;
    logic           m_last;
    logic           overflow;
    logic [7:0]     drop_count;
    logic           ovf_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_n   = 0;
    int hs_first = 0;
    int hs_last  = 0;

    beat_t exp_q[$];

    logic           prev_stall = 1'b0;
    logic [W-1:0]   prev_data;
    logic [2:0]     prev_index;
    logic           prev_last;

    sort_result_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_ready  (vec_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .overflow   (overflow),
        .drop_count (drop_count),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [W-1:0] e0, e1, e2, e3, e4, e5, e6, e7);
        vec_t v;
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
        v[4] = e4; v[5] = e5; v[6] = e6; v[7] = e7;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_vec(input vec_t v);
        beat_t b;
        for (int i = 0; i < D; i++) begin
            b.data  = v[i];
            b.index = 3'(i);
            b.last  = (i == D - 1);
            exp_q.push_back(b);
        end
    endtask

    // One-cycle pulse; returns just after the capture edge
    task automatic send_vec(input vec_t v);
        @(posedge clk); #1;
        vec_valid = 1'b1;
        vec_data  = v;
        @(posedge clk); #1;
        vec_valid = 1'b0;
    endtask

    // Run until the scoreboard is drained, optionally toggling m_ready
    task automatic drain(input bit bp);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            m_ready = bp ? ~m_ready : 1'b1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d beats left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Stream monitor: hold-while-stalled rule and scoreboard compare on every handshake
    always @(negedge clk) begin
        beat_t b;
        cyc++;
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== prev_data || m_index !== prev_index || m_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold: got v=%0b d=%0h i=%0d l=%0b expected v=1 d=%0h i=%0d l=%0b",
                             m_valid, m_data, m_index, m_last, prev_data, prev_index, prev_last);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_extra: got d=%0h i=%0d expected no beat", m_data, m_index);
                end else begin
                    b = exp_q.pop_front();
                    if (m_data !== b.data || m_index !== b.index || m_last !== b.last) begin
                        errors++;
                        $display("FAIL beat: got d=%0h i=%0d l=%0b expected d=%0h i=%0d l=%0b",
                                 m_data, m_index, m_last, b.data, b.index, b.last);
                    end
                end
                if (hs_n == 0) hs_first = cyc;
                hs_last = cyc;
                hs_n++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_index = m_index;
            prev_last  = m_last;
        end
    end

    rec_t tbl[3];
    vec_t va, vb, vc;

    initial begin
        tbl[0].vec = mk(1, 2, 3, 5, 7, 10, 18, 25);                  tbl[0].bp = 1'b0;
        tbl[1].vec = mk(1, 2, 3, 5, 7, 10, 18, 25);                  tbl[1].bp = 1'b1;
        tbl[2].vec = mk(0, 9, 'h100, 'h1234, 'hABCD0, 'h7FFFFFFF, 'h80000000, 'hFFFFFFFF);
        tbl[2].bp  = 1'b1;
        va = mk('hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5, 'hA6, 'hA7);
        vb = mk('hB0, 'hB1, 'hB2, 'hB3, 'hB4, 'hB5, 'hB6, 'hB7);
        vc = mk('hC0, 'hC1, 'hC2, 'hC3, 'hC4, 'hC5, 'hC6, 'hC7);

        rst = 1'b0; vec_valid = 1'b0; vec_data = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_index", 32'(m_index), 0);
        check("rst_m_last", 32'(m_last), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        check("rst_vec_ready", 32'(vec_ready), 1);

        // Single vectors, with and without backpressure
        for (int t = 0; t < 3; t++) begin
            m_ready = 1'b1;
            hs_n = 0;
            push_vec(tbl[t].vec);
            send_vec(tbl[t].vec);
            @(negedge clk);
            check("latency_valid", 32'(m_valid), 1);
            check("latency_index", 32'(m_index), 0);
            drain(tbl[t].bp);
            @(negedge clk);
            check("idle_after", 32'(m_valid), 0);
            check("beats_once", hs_n, 8);
            if (!tbl[t].bp) check("no_gap_single", hs_last - hs_first, 7);
        end

        // Two vectors three cycles apart stream back to back
        m_ready = 1'b1;
        hs_n = 0;
        push_vec(va);
        send_vec(va);
        @(posedge clk); #1;
        push_vec(vb);
        send_vec(vb);
        @(negedge clk);
        check("both_held_vec_ready", 32'(vec_ready), 0);
        drain(1'b0);
        @(negedge clk);
        check("two_vec_beats", hs_n, 16);
        check("two_vec_no_gap", hs_last - hs_first, 15);

        // Three consecutive pulses while stalled: third is dropped
        m_ready = 1'b0;
        @(posedge clk); #1;
        push_vec(va); push_vec(vb);
        vec_valid = 1'b1; vec_data = va;
        @(posedge clk); #1 vec_data = vb;
        @(posedge clk); #1 vec_data = vc;
        @(posedge clk); #1 vec_valid = 1'b0;
        @(negedge clk);
        check("drop_overflow", 32'(overflow), 1);
        check("drop_count", 32'(drop_count), 1);
        check("drop_vec_ready", 32'(vec_ready), 0);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk);
        check("clr_overflow", 32'(overflow), 0);
        check("clr_drop_count", 32'(drop_count), 0);
        drain(1'b0);

        // Both slots full, new vector coincides with the release beat
        m_ready = 1'b0;
        push_vec(va); push_vec(vb); push_vec(vc);
        send_vec(va);
        send_vec(vb);
        @(posedge clk); #1 m_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1 vec_valid = 1'b1; vec_data = vc;
        @(posedge clk); #1 vec_valid = 1'b0;
        @(negedge clk);
        check("coincide_overflow", 32'(overflow), 0);
        check("coincide_drop_count", 32'(drop_count), 0);
        check("coincide_vec_ready", 32'(vec_ready), 0);
        drain(1'b0);
        @(negedge clk);
        check("coincide_idle", 32'(m_valid), 0);

        // Reset in the middle of a vector
        m_ready = 1'b1;
        hs_n = 0;
        push_vec(tbl[2].vec);
        send_vec(tbl[2].vec);
        for (int n = 0; n < 50 && hs_n < 4; n++) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_index", 32'(m_index), 0);
        check("midrst_m_last", 32'(m_last), 0);
        check("midrst_vec_ready", 32'(vec_ready), 1);
        @(posedge clk); #1 rst = 1'b1;
        push_vec(tbl[0].vec);
        send_vec(tbl[0].vec);
        @(negedge clk);
        check("post_rst_index", 32'(m_index), 0);
        drain(1'b0);
        @(negedge clk);
        check("post_rst_idle", 32'(m_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_result_serializer.md
# sort_result_serializer

Receives completed DEPTH-element sorted vectors from the bitonic sorter's output port (single-cycle `valid_out` pulse, no backpressure) and streams them out one element per beat over a valid/ready interface, ascending order, with a last-beat marker. Two vector slots (ping-pong) absorb sorter results while downstream stalls. Vectors arriving with both slots occupied are dropped and flagged. Sits between the sorter and any serial consumer (FIFO, DMA, UART framer).

## Interface
- WIDTH, 32, element width in bits
- DEPTH, 8, elements per vector; power of two, ≥2
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- vec_valid  in  1  one-cycle pulse: `vec_data` holds a sorted vector
- vec_data  in  WIDTH×[DEPTH]  sorted vector; index 0 = smallest
- vec_ready  out  1  advisory: a slot is free this cycle
- m_valid  out  1  stream beat valid
- m_ready  in  1  downstream accepts beat
- m_data  out  WIDTH  current element
- m_index  out  $clog2(DEPTH)  element index within vector
- m_last  out  1  high on the index DEPTH-1 beat
- overflow  out  1  sticky: a vector was dropped
- drop_count  out  8  dropped vectors, saturates at 255
- ovf_clr  in  1  synchronous clear of `overflow` and `drop_count`

## Operation
- Storage: slot[0..1] of DEPTH×WIDTH registers; `wr_ptr`, `rd_ptr` (1 bit each); `count` (0..2); element counter `idx`.
- Reset values: slots don't-care; count=0, ptrs=0, idx=0; m_valid=0, m_data=0, m_index=0, m_last=0, overflow=0, drop_count=0, vec_ready=1.
- `vec_ready` = (count<2). Combinational from registers only.
- A beat handshakes when m_valid && m_ready. A "release" occurs on the handshake of the idx==DEPTH-1 beat.
- Capture: on vec_valid, accepted if count<2 OR a release happens in the same cycle. Accepted → write slot[wr_ptr], toggle wr_ptr.
- Drop: vec_valid with count==2 and no release → slot contents unchanged; overflow←1; drop_count+1 (saturating).
- count next = count + accept − release.
- FSM, enum in package: IDLE (count==0, m_valid=0) and STREAM (m_valid=1).
  - IDLE → STREAM on accept; idx=0.
  - STREAM, handshake, idx<DEPTH-1 → idx+1.
  - STREAM, release → idx=0, toggle rd_ptr; stay STREAM if the other slot is full or being written this cycle, else IDLE.
- m_data = slot[rd_ptr][idx]; m_index = idx; m_last = (idx==DEPTH-1) && m_valid.
- AXI-stream rules: while m_valid && !m_ready, m_data/m_index/m_last are held; m_valid never drops without a handshake.
- ovf_clr has priority over a simultaneous drop: counters clear; that drop is not recorded.
- Reset asserted mid-stream: all state returns to reset values immediately (async); partially streamed vectors are discarded and not resumed.

## Timing
- Capture at edge N → m_valid high after edge N (element 0 visible in cycle N+1). Latency one cycle.
- Throughput: one element per cycle with m_ready held high. Back-to-back vectors stream with no bubble between the last beat of one and index 0 of the next.
- A vector occupies its slot for ≥DEPTH cycles. Sorter pulses spaced ≥DEPTH cycles never drop at full m_ready.
- No combinational path from vec_valid or m_ready to any output except via registers. vec_ready depends only on count.

## Structure
- `sort_pkg`: default WIDTH/DEPTH localparams; `elem_t` = logic [WIDTH-1:0]; `ser_state_e` {IDLE, STREAM}; IDX_W = $clog2(DEPTH).
- Single module. The slot array is plain registers, with no sub-module. Drop/overflow accounting is inline.

## Test plan
- Single vector {1,2,3,5,7,10,18,25}, m_ready=1 → beats 1..25 on 8 consecutive cycles starting the cycle after capture; m_index 0..7; m_last only with 25; then m_valid=0.
- Backpressure: same vector, m_ready toggling 1/0 → each value held stable while stalled; the full ordered sequence is delivered exactly once.
- Two vectors captured 3 cycles apart, m_ready=1 → 16 beats with no gap; vec_ready=0 while both slots are held.
- m_ready=0, three pulses on consecutive cycles → first two vectors are held, third is dropped; overflow=1, drop_count=1. Then ovf_clr → both return to 0.
- count==2, vec_valid coincident with the release beat → vector accepted, no drop, streams after the remaining slot.
- rst low at beat 4 of 8 → all outputs return to reset values immediately. After release, a new vector streams from index 0.
